cic_decim_ctrl: RTL

CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_shift_calc.sv | 28 ++
 rtl/cic_decim_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared state encoding, default sizes and clog2 helper for the CIC decimator controller
package cic_pkg;

  localparam int STAGES_DEF      = 4;
  localparam int RATE_WIDTH_DEF  = 8;
  localparam int SHIFT_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } cic_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cic_shift_calc.sv
// rtl/cic_shift_calc.sv - gain-normalisation shift: priority-encoded ceil(log2(rate)) times STAGES
module cic_shift_calc
  import cic_pkg::*;
#(
  parameter int STAGES      = STAGES_DEF,
  parameter int RATE_WIDTH  = RATE_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic [RATE_WIDTH-1:0]  rate,
  output logic [SHIFT_WIDTH-1:0] shift
);

  localparam int LOG_W = clog2(RATE_WIDTH + 1);

  logic [RATE_WIDTH-1:0] rate_m1;
  logic [LOG_W-1:0]      ceil_log;

  // ceil(log2(R)) is one past the highest set bit of R-1 (valid for R >= 2)
  always_comb begin
    rate_m1  = rate - RATE_WIDTH'(1);
    ceil_log = '0;
    for (int i = 0; i < RATE_WIDTH; i++) begin
      if (rate_m1[i]) ceil_log = LOG_W'(i + 1);
    end
    shift = SHIFT_WIDTH'(int'(ceil_log) * STAGES);
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer: flush/run FSM, decimation counter, rate and gain-shift registers
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int STAGES      = STAGES_DEF,
  parameter int RATE_WIDTH  = RATE_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   strobe_in,
  input  logic                   rate_load,
  input  logic [RATE_WIDTH-1:0]  rate_in,
  output logic                   int_enable,
  output logic                   int_clear,
  output logic                   comb_strobe,
  output logic                   strobe_out,
  output logic [SHIFT_WIDTH-1:0] shift,
  output logic                   busy,
  output logic                   rate_err
);

  localparam int FLUSH_W = clog2(STAGES + 1);

  cic_state_t             state, state_nxt;
  logic [RATE_WIDTH-1:0]  rate_q;
  logic [RATE_WIDTH-1:0]  cnt_q;
  logic [FLUSH_W-1:0]     flush_q;
  logic [SHIFT_WIDTH-1:0] shift_new;
  logic                   rate_ok;
  logic                   reload;
  logic                   enter_flush;
  logic                   wrap;
  logic                   flush_done;

  cic_shift_calc #(
    .STAGES      (STAGES),
    .RATE_WIDTH  (RATE_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift_calc (
    .rate  (rate_in),
    .shift (shift_new)
  );

  assign rate_ok     = rate_load && (rate_in >= RATE_WIDTH'(2));
  assign reload      = rate_ok && enable && (state != ST_IDLE);
  assign enter_flush = enable && ((state == ST_IDLE) || reload);
  assign busy        = (state != ST_IDLE);
  assign int_enable  = strobe_in && busy && !int_clear;
  assign wrap        = int_enable && (cnt_q == rate_q - RATE_WIDTH'(1));
  assign flush_done  = comb_strobe && (state == ST_FLUSH) && (flush_q == FLUSH_W'(STAGES - 1));

  // enable low overrides everything; a valid reload restarts the flush
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_done) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (reload) state_nxt = ST_FLUSH;
    if (!enable) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rate_q      <= RATE_WIDTH'(2);
      shift       <= SHIFT_WIDTH'(STAGES);
      cnt_q       <= '0;
      flush_q     <= '0;
      int_clear   <= 1'b0;
      comb_strobe <= 1'b0;
      strobe_out  <= 1'b0;
      rate_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      int_clear  <= enter_flush;
      rate_err   <= rate_load && !rate_ok;
      strobe_out <= enable && comb_strobe && (state == ST_RUN);
      if (rate_ok) begin
        rate_q <= rate_in;
        shift  <= shift_new;
      end
      if ((state_nxt == ST_IDLE) || enter_flush) begin
        cnt_q       <= '0;
        flush_q     <= '0;
        comb_strobe <= 1'b0;
      end else begin
        comb_strobe <= wrap;
        if (int_enable) cnt_q <= wrap ? '0 : cnt_q + RATE_WIDTH'(1);
        if (comb_strobe && (state == ST_FLUSH)) begin
          flush_q <= flush_done ? '0 : flush_q + FLUSH_W'(1);
        end
      end
    end
  end

endmodule
